btn_debounce_pulse: RTL and testbench

- Front-end stage for the toggle flip-flop block. It turns a raw, bouncing, asynchronous push-button/switch input into a clean debounced level plus a single-cycle toggle-enable pulse (`t_pulse`).
- `t_pulse` drives the flip-flop's `t` input directly.
- Structure: a 2-flop synchronizer, a stability counter and a 4-state FSM.

---
 rtl/btn_debounce_pkg.sv | 14 +
 rtl/sync_2ff.sv | 24 ++
 rtl/btn_debounce_pulse.sv | 134 +++++++++++++
 tb/tb_btn_debounce_pulse.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared types and default constants for the button debounce front end.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        HELD_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam int STABLE_CYCLES_DEF = 50000;
    localparam int CNT_W_DEF         = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounces a raw button into a clean level plus one-cycle press (t_pulse) pulse.
// Define BTN_DEBOUNCE_FALL_PULSE_EN to also emit a one-cycle release pulse on t_fall.
module btn_debounce_pulse
    import btn_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic t_pulse,
    output logic t_fall,
    output logic busy
);

    generate
        if (STABLE_CYCLES < 2) begin : g_chk_stable
            $error("btn_debounce_pulse: STABLE_CYCLES must be >= 2");
        end
        if (!((2 ** CNT_W) > STABLE_CYCLES)) begin : g_chk_width
            $error("btn_debounce_pulse: CNT_W too narrow for STABLE_CYCLES");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic s;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (s)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    // Counter is cleared on every state change, so it never needs to wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = HELD_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

`ifdef BTN_DEBOUNCE_FALL_PULSE_EN
    logic fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= fall_d;
        end
    end

    assign t_fall = fall_q;
`else
    logic unused_fall;
    assign unused_fall = fall_d;
    assign t_fall      = 1'b0;
`endif

    assign btn_level = level_q;
    assign t_pulse   = pulse_q;
    assign busy      = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed self-checking bench for btn_debounce_pulse with STABLE_CYCLES=4, CNT_W=3.
module tb_btn_debounce_pulse;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_raw;
    logic btn_level;
    logic t_pulse;
    logic t_fall;
    logic busy;

    int vectors   = 0;
    int errors    = 0;
    int pulse_cnt = 0;
    int fall_cnt  = 0;
    int consec    = 0;
    logic prev_pulse = 1'b0;
    logic prev_fall  = 1'b0;
    logic tff_q;

`ifdef BTN_DEBOUNCE_FALL_PULSE_EN
    localparam logic FALL_EXP = 1'b1;
    localparam int   FALL_PER = 1;
`else
    localparam logic FALL_EXP = 1'b0;
    localparam int   FALL_PER = 0;
`endif

    btn_debounce_pulse #(
        .STABLE_CYCLES (4),
        .CNT_W         (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .t_pulse   (t_pulse),
        .t_fall    (t_fall),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Downstream toggle flip-flop fed by t_pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tff_q <= 1'b0;
        else if (t_pulse) tff_q <= ~tff_q;
    end

    always @(negedge clk) begin
        if (t_pulse) pulse_cnt++;
        if (t_fall) fall_cnt++;
        if ((t_pulse && prev_pulse) || (t_fall && prev_fall)) consec++;
        prev_pulse = t_pulse;
        prev_fall  = t_fall;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int base;

    initial begin
        // Reset held with button already pressed.
        rst_n   = 1'b0;
        btn_raw = 1'b1;
        step(3);
        chk("rst_level", btn_level, 0);
        chk("rst_pulse", t_pulse, 0);
        chk("rst_fall",  t_fall, 0);
        chk("rst_busy",  busy, 0);

        rst_n = 1'b1;
        step(6);
        chk("rel_k5_pulse", t_pulse, 0);
        chk("rel_k5_busy",  busy, 1);
        chk("rel_k5_level", btn_level, 0);
        step(1);
        chk("rel_k6_pulse", t_pulse, 1);
        chk("rel_k6_level", btn_level, 1);
        chk("rel_k6_busy",  busy, 0);
        step(1);
        chk("rel_k7_pulse", t_pulse, 0);
        chk("rel_pulse_cnt", pulse_cnt, 1);
        chk("tff_after_1", tff_q, 1);

        // Release.
        btn_raw = 1'b0;
        step(6);
        chk("fall_k5_level", btn_level, 1);
        chk("fall_k5_busy",  busy, 1);
        step(1);
        chk("fall_k6_level", btn_level, 0);
        chk("fall_k6_tfall", t_fall, FALL_EXP);
        chk("fall_k6_busy",  busy, 0);
        step(1);
        chk("fall_k7_tfall", t_fall, 0);
        chk("fall_cnt_1", fall_cnt, FALL_PER);

        // Clean press held 20 cycles.
        base    = pulse_cnt;
        btn_raw = 1'b1;
        step(2);
        chk("clean_k1_busy", busy, 0);
        step(1);
        chk("clean_k2_busy", busy, 1);
        step(3);
        chk("clean_k5_busy",  busy, 1);
        chk("clean_k5_pulse", t_pulse, 0);
        step(1);
        chk("clean_k6_pulse", t_pulse, 1);
        chk("clean_k6_level", btn_level, 1);
        step(13);
        chk("clean_hold_pulse", t_pulse, 0);
        chk("clean_hold_level", btn_level, 1);
        chk("clean_pulse_cnt", pulse_cnt - base, 1);
        chk("tff_after_2", tff_q, 0);
        btn_raw = 1'b0;
        step(10);
        chk("clean_rel_level", btn_level, 0);

        // Bounce 1,0,1,0 every 2 cycles then steady high.
        base    = pulse_cnt;
        btn_raw = 1'b1; step(2);
        btn_raw = 1'b0; step(2);
        btn_raw = 1'b1; step(2);
        btn_raw = 1'b0; step(2);
        chk("bounce_no_pulse", pulse_cnt - base, 0);
        chk("bounce_level",    btn_level, 0);
        btn_raw = 1'b1;
        step(6);
        chk("bounce_k5_pulse", t_pulse, 0);
        chk("bounce_k5_cnt",   pulse_cnt - base, 0);
        step(1);
        chk("bounce_k6_pulse", t_pulse, 1);
        chk("bounce_k6_level", btn_level, 1);
        step(1);
        chk("tff_after_3", tff_q, 1);
        chk("total_pulses", pulse_cnt, 3);
        btn_raw = 1'b0;
        step(10);
        chk("bounce_rel_level", btn_level, 0);
        chk("fall_cnt_3", fall_cnt, 3 * FALL_PER);

        // Reset in the middle of qualification.
        base    = pulse_cnt;
        btn_raw = 1'b1;
        step(4);
        chk("midrst_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",  busy, 0);
        chk("midrst_level", btn_level, 0);
        btn_raw = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(10);
        chk("midrst_no_pulse", pulse_cnt - base, 0);
        chk("midrst_level_post", btn_level, 0);
        chk("midrst_busy_post",  busy, 0);
        chk("no_consecutive", consec, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
